period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 17 +
 rtl/period_meter_edge_detect.sv | 50 +++++
 rtl/period_meter.sv | 133 +++++++++++++
 tb/tb_period_meter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: measurement state encoding and
// the default counter/result width.
// Optional build macro (used by edge_detect): PERIOD_METER_SYNC_EN.
package period_meter_pkg;

  // Default width of the period counter and of the reported result.
  localparam int unsigned PM_W_DEFAULT = 32;

  // Measurement sequencing: wait for enable, wait for a first edge,
  // then time edge-to-edge distances.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } pm_state_e;

endpackage

// File: rtl/period_meter_edge_detect.sv
// Rising-edge detector for the measured strobe. Produces a one-cycle rise
// strobe; a strobe held high yields a single rise.
// Build macro PERIOD_METER_SYNC_EN: when defined, pulse_i first passes a
// two-flop synchronizer (cleared by clr_i), which delays the strobe by two
// cycles but leaves edge spacing, and hence measured periods, unchanged.
module edge_detect
  import period_meter_pkg::*;
(
  input  logic clk_i,
  input  logic clr_i,
  input  logic pulse_i,
  output logic rise_o
);

  logic w_sample;
  logic r_prev;

`ifdef PERIOD_METER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for a strobe coming from another clock domain.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pulse_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  // Same-clock-domain strobe: sampled directly.
  assign w_sample = pulse_i;
`endif

  // Edge history: previous value of the (optionally synchronized) strobe.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_sample;
    end
  end

  assign rise_o = w_sample & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// Period meter: measures the distance, in clk_i cycles, between successive
// rising edges of pulse_i and hands results to a consumer with a
// valid/ready handshake. Saturates at 2^W-1 when no second edge arrives.
// Build macro PERIOD_METER_SYNC_EN: adds a 2-flop input synchronizer in
// edge_detect (2 extra cycles of latency, same measured periods).
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned W = PM_W_DEFAULT
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         pulse_i,
  input  logic         en_i,
  output logic [W-1:0] period_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         ovf_o,
  output logic         lost_o
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  pm_state_e    r_state;
  pm_state_e    w_state_next;
  logic [W-1:0] r_count;
  logic [W-1:0] w_count_next;
  logic         w_rise;
  logic         w_res_fire;
  logic         w_res_sat;
  logic [W-1:0] w_res_value;

  logic [W-1:0] r_period;
  logic         r_valid;
  logic         r_ovf;
  logic         r_lost;

  edge_detect u_edge_detect (
    .clk_i   (clk_i),
    .clr_i   (clr_i),
    .pulse_i (pulse_i),
    .rise_o  (w_rise)
  );

  // State and counter register; reset discards any partial count.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next state, counter update and result generation. The counter holds the
  // number of cycles since the last edge, so at the next edge it equals the
  // edge spacing directly. Reaching the ceiling without an edge reports a
  // saturated result and re-arms for a fresh first edge.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_res_fire   = 1'b0;
    w_res_sat    = 1'b0;
    w_res_value  = r_count;
    if (!en_i) begin
      w_state_next = ST_IDLE;
      w_count_next = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_next = ST_ARMED;
          w_count_next = '0;
        end
        ST_ARMED: begin
          if (w_rise) begin
            w_state_next = ST_MEASURE;
            w_count_next = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            w_res_fire   = 1'b1;
            w_res_value  = r_count;
            w_count_next = CNT_ONE;
          end else if (r_count == CNT_MAX) begin
            w_res_fire   = 1'b1;
            w_res_sat    = 1'b1;
            w_res_value  = CNT_MAX;
            w_state_next = ST_ARMED;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CNT_ONE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
        end
      endcase
    end
  end

  // Result register and handshake. A new result wins over an acceptance in
  // the same cycle; overwriting an unaccepted result flags lost_o (sticky).
  // With the meter disabled the outputs are frozen.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_period <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_lost   <= 1'b0;
    end else if (en_i) begin
      if (w_res_fire) begin
        r_period <= w_res_value;
        r_valid  <= 1'b1;
        r_ovf    <= w_res_sat;
        if (r_valid && !ready_i) begin
          r_lost <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign period_o = r_period;
  assign valid_o  = r_valid;
  assign ovf_o    = r_ovf;
  assign lost_o   = r_lost;

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter (W=8). Stimulus is issued cycle by cycle; a
// reference model derived from edge times pushes expected results into a
// scoreboard queue, and an independent monitor pops and compares on every
// accepted result. Honours PERIOD_METER_SYNC_EN (2-cycle strobe delay).
module tb_period_meter;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;
`ifdef PERIOD_METER_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic         pulse;
  logic         en;
  logic         ready;
  logic [W-1:0] period;
  logic         valid;
  logic         ovf;
  logic         lost;

  always #5 clk = ~clk;

  period_meter #(.W(W)) dut (
    .clk_i    (clk),
    .clr_i    (clr),
    .pulse_i  (pulse),
    .en_i     (en),
    .period_o (period),
    .valid_o  (valid),
    .ready_i  (ready),
    .ovf_o    (ovf),
    .lost_o   (lost)
  );

  typedef struct {
    int period;
    bit ovf;
    bit lost;
    int appear;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   zero_chk_cyc = -1;

  // Reference model state: 0 idle, 1 waiting for first edge, 2 timing.
  int   m_mode = 0;
  int   m_last = 0;
  bit   m_pending = 0;
  bit   m_lost = 0;
  bit   m_prev = 0;
  bit   m_dl0 = 0;
  bit   m_dl1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Apply the rules to the inputs of the current cycle (index cyc).
  task automatic model_step();
    bit   p_eff;
    bit   edge_seen;
    bit   have_res;
    int   d;
    exp_t e;
    if (clr) begin
      m_mode = 0; m_pending = 0; m_lost = 0;
      m_prev = 0; m_dl0 = 0; m_dl1 = 0;
      exp_q.delete();
      zero_chk_cyc = cyc + 1;
      return;
    end
    p_eff     = (DLY == 0) ? pulse : m_dl1;
    edge_seen = p_eff && !m_prev;
    m_prev    = p_eff;
    m_dl1     = m_dl0;
    m_dl0     = pulse;
    if (!en) begin
      m_mode = 0;
      return;
    end
    have_res = 0;
    e.period = 0; e.ovf = 0; e.lost = 0; e.appear = 0;
    case (m_mode)
      0: m_mode = 1;
      1: if (edge_seen) begin m_mode = 2; m_last = cyc; end
      default: begin
        d = cyc - m_last;
        if (edge_seen) begin
          have_res = 1; e.period = d; e.ovf = 0; m_last = cyc;
        end else if (d >= MAXV) begin
          have_res = 1; e.period = MAXV; e.ovf = 1; m_mode = 1;
        end
      end
    endcase
    if (have_res) begin
      e.appear = cyc + 1;
      if (m_pending && !ready) begin
        m_lost = 1;
        e.lost = 1;
        exp_q[exp_q.size() - 1] = e;
      end else begin
        e.lost = m_lost;
        exp_q.push_back(e);
      end
      m_pending = 1;
    end else if (m_pending && ready) begin
      m_pending = 0;
    end
  endtask

  task automatic step(input bit p, input bit r, input bit c, input bit e);
    @(posedge clk);
    #1;
    pulse = p; ready = r; clr = c; en = e;
    model_step();
  endtask

  // rdy: 0/1 fixed, 2 random.
  task automatic tick_train(input int per, input int n, input int hi, input int rdy);
    bit r;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < per; i++) begin
        r = (rdy == 2) ? bit'($urandom_range(0, 1)) : bit'(rdy);
        step(i < hi, r, 1'b0, 1'b1);
      end
    end
  endtask

  // Monitor: checks reset/clear state, result latency and accepted results.
  bit   prev_valid = 0;
  exp_t got;
  always @(negedge clk) begin
    if (cyc == zero_chk_cyc) begin
      checks++;
      if (period != 0 || valid || ovf || lost) begin
        errors++;
        $display("FAIL clear_state: got period=%0d valid=%0b ovf=%0b lost=%0b required all 0 (cycle %0d)",
                 period, valid, ovf, lost, cyc);
      end
    end
    if (valid && !prev_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL valid_rise: got valid=1 with period=%0d required no result (cycle %0d)", period, cyc);
      end else if (exp_q[0].appear != cyc) begin
        errors++;
        $display("FAIL valid_latency: got rise at cycle %0d required cycle %0d", cyc, exp_q[0].appear);
      end
    end
    if (valid && ready && en && !clr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got period=%0d ovf=%0b required none (cycle %0d)", period, ovf, cyc);
      end else begin
        got = exp_q.pop_front();
        if (int'(period) != got.period || ovf != got.ovf || lost != got.lost) begin
          errors++;
          $display("FAIL result: got period=%0d ovf=%0b lost=%0b required period=%0d ovf=%0b lost=%0b (cycle %0d)",
                   period, ovf, lost, got.period, got.ovf, got.lost, cyc);
        end else begin
          $display("txn cycle=%0d period=%0d ovf=%0b lost=%0b", cyc, period, ovf, lost);
        end
      end
    end
    prev_valid = valid;
  end

  initial begin
    int per;
    int hi;
    pulse = 0; ready = 0; clr = 1; en = 0;
    model_step();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1);

    // Steady 100-cycle ticks, always ready.
    tick_train(100, 6, 1, 1);
    // 7-cycle ticks with the consumer stalled, then draining.
    tick_train(7, 4, 1, 0);
    tick_train(7, 2, 1, 1);
    // Single edge then silence: saturation, then recovery with 50-cycle ticks.
    step(1, 1, 0, 1);
    for (int i = 0; i < 300; i++) step(0, 1, 0, 1);
    tick_train(50, 3, 1, 1);
    // Strobe held high 50 cycles, rising every 80.
    tick_train(80, 4, 50, 1);
    // Clear 40 cycles into a 100-cycle period.
    tick_train(100, 2, 1, 1);
    step(1, 1, 0, 1);
    for (int i = 0; i < 39; i++) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    for (int i = 0; i < 60; i++) step(0, 1, 0, 1);
    tick_train(100, 3, 1, 1);
    // Minimum spacing of 2.
    tick_train(2, 6, 1, 1);
    // Disabled for a while with strobes present.
    for (int i = 0; i < 12; i++) step(bit'(i % 3 == 0), 1, 0, 0);
    tick_train(20, 3, 1, 1);
    // Randomized spacing, duty and consumer backpressure.
    for (int s = 0; s < 30; s++) begin
      per = $urandom_range(2, 40);
      hi  = $urandom_range(1, per - 1);
      tick_train(per, $urandom_range(1, 4), hi, 2);
    end
    tick_train(260, 2, 1, 2);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unconsumed expected results required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
